// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer: load-use, EX-resolved redirects and data-memory
// waits with a timeout watchdog, plus saturating stall/flush event counters.
module hazard_controller #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_WIDTH   = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [4:0]           rs1D,
   input  logic [4:0]           rs2D,
   input  logic [4:0]           rdE,
   input  logic                 loadE,
   input  logic                 PCSrcE,
   input  logic                 dmem_reqM,
   input  logic                 dmem_ready,
   output logic                 stallF,
   output logic                 stallD,
   output logic                 stallE,
   output logic                 stallM,
   output logic                 flushD,
   output logic                 flushE,
   output logic                 flushW,
   output logic                 bus_error,
   output logic [CNT_WIDTH-1:0] stall_cnt,
   output logic [CNT_WIDTH-1:0] flush_cnt
);

   typedef enum logic [1:0] {RUN, WAIT, ERROR} state_e;

   localparam logic [7:0]           TIMEOUT = MEM_TIMEOUT[7:0];
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   state_e               state_q, state_d;
   logic [7:0]           wait_ctr_q, wait_ctr_d;
   logic                 bus_error_q, bus_error_d;
   logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

   logic memStall;
   logic lwStall;
   logic flush_win;

   assign memStall = (state_q == WAIT) | ((state_q == RUN) & dmem_reqM & ~dmem_ready);
   assign lwStall  = loadE & (rdE != 5'd0) & ((rs1D == rdE) | (rs2D == rdE));

   // Pipeline controls, highest priority first.
   always_comb begin
      stallF    = 1'b0;
      stallD    = 1'b0;
      stallE    = 1'b0;
      stallM    = 1'b0;
      flushD    = 1'b0;
      flushE    = 1'b0;
      flushW    = 1'b0;
      flush_win = 1'b0;
      if (reset) begin
         flushD = 1'b1;
         flushE = 1'b1;
         flushW = 1'b1;
      end else if (state_q == ERROR) begin
         stallF = 1'b1;
         stallD = 1'b1;
         stallE = 1'b1;
         stallM = 1'b1;
      end else if (memStall) begin
         stallF = 1'b1;
         stallD = 1'b1;
         stallE = 1'b1;
         stallM = 1'b1;
         flushW = 1'b1;
      end else if (PCSrcE) begin
         flushD    = 1'b1;
         flushE    = 1'b1;
         flush_win = 1'b1;
      end else if (lwStall) begin
         stallF = 1'b1;
         stallD = 1'b1;
         flushE = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      wait_ctr_d  = wait_ctr_q;
      bus_error_d = bus_error_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      unique case (state_q)
         RUN: begin
            if (dmem_reqM && !dmem_ready) begin
               state_d    = WAIT;
               wait_ctr_d = 8'd1;
            end
         end
         WAIT: begin
            // Ready takes precedence over an expiring timeout in the same cycle.
            if (dmem_ready) begin
               state_d    = RUN;
               wait_ctr_d = 8'd0;
            end else if (wait_ctr_q == TIMEOUT) begin
               state_d     = ERROR;
               bus_error_d = 1'b1;
            end else begin
               wait_ctr_d = wait_ctr_q + 8'd1;
            end
         end
         ERROR: state_d = ERROR;
         default: state_d = RUN;
      endcase
      if (stallF && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      if (flush_win && (flush_cnt_q != '1))
         flush_cnt_d = flush_cnt_q + CNT_ONE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= RUN;
         wait_ctr_q  <= '0;
         bus_error_q <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_ctr_q  <= wait_ctr_d;
         bus_error_q <= bus_error_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus_error = bus_error_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Randomized self-checking bench for hazard_controller with a behavioural
// model compared every cycle, plus directed literal checks of key scenarios.
module tb_hazard_controller;

   localparam int unsigned TO   = 4;
   localparam int unsigned CW   = 4;
   localparam int          MAXC = (1 << CW) - 1;

   logic          clk;
   logic          reset;
   logic [4:0]    rs1D, rs2D, rdE;
   logic          loadE, PCSrcE, dmem_reqM, dmem_ready;
   logic          stallF, stallD, stallE, stallM;
   logic          flushD, flushE, flushW, bus_error;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int checks   = 0;
   int failures = 0;
   bit running  = 1'b1;

   hazard_controller #(.MEM_TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .rdE(rdE),
      .loadE(loadE), .PCSrcE(PCSrcE), .dmem_reqM(dmem_reqM), .dmem_ready(dmem_ready),
      .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
      .flushD(flushD), .flushE(flushE), .flushW(flushW), .bus_error(bus_error),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic ld, input logic pc, input logic req,
                        input logic rdy, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] d);
      @(posedge clk);
      #1;
      reset = r; loadE = ld; PCSrcE = pc; dmem_reqM = req; dmem_ready = rdy;
      rs1D = a; rs2D = b; rdE = d;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
   endtask

   // Behavioural model: hazard mode, cycles spent waiting, counters.
   bit m_valid = 1'b0;
   bit m_err, m_in_wait, m_berr;
   int m_waited, m_scnt, m_fcnt;

   always @(negedge clk) begin
      if (running) begin
         bit lw, mem, pc_wins;
         logic [6:0] exp_v, act_v;
         lw  = loadE && (rdE != 0) && ((rs1D == rdE) || (rs2D == rdE));
         mem = m_in_wait || (!m_err && dmem_reqM && !dmem_ready);
         pc_wins = 1'b0;
         if (reset)         exp_v = 7'b0000_111;
         else if (m_err)    exp_v = 7'b1111_000;
         else if (mem)      exp_v = 7'b1111_001;
         else if (PCSrcE) begin
            exp_v = 7'b0000_110;
            pc_wins = 1'b1;
         end
         else if (lw)       exp_v = 7'b1100_010;
         else               exp_v = 7'b0000_000;
         act_v = {stallF, stallD, stallE, stallM, flushD, flushE, flushW};
         if (reset || m_valid) chk("ctrl", 32'(act_v), 32'(exp_v));
         if (m_valid) begin
            chk("bus_error", 32'(bus_error), 32'(m_berr));
            chk("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
            chk("flush_cnt", 32'(flush_cnt), 32'(m_fcnt));
         end
         if (reset) begin
            m_valid = 1'b1; m_err = 1'b0; m_in_wait = 1'b0; m_berr = 1'b0;
            m_waited = 0; m_scnt = 0; m_fcnt = 0;
         end else if (m_valid) begin
            if (exp_v[6] && m_scnt < MAXC) m_scnt++;
            if (pc_wins && m_fcnt < MAXC) m_fcnt++;
            if (m_err) begin
               // terminal
            end else if (m_in_wait) begin
               if (dmem_ready) begin
                  m_in_wait = 1'b0; m_waited = 0;
               end else if (m_waited == TO) begin
                  m_err = 1'b1; m_berr = 1'b1; m_in_wait = 1'b0;
               end else m_waited++;
            end else if (dmem_reqM && !dmem_ready) begin
               m_in_wait = 1'b1; m_waited = 1;
            end
         end
      end
   end

   initial begin
      reset = 1'b1; loadE = 1'b0; PCSrcE = 1'b0; dmem_reqM = 1'b0; dmem_ready = 1'b0;
      rs1D = '0; rs2D = '0; rdE = '0;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      chk("rst_stallF", 32'(stallF), 32'd0);
      chk("rst_flushW", 32'(flushW), 32'd1);

      // Load-use, then the same with rdE=x0.
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 5'd0, 5'd5);
      chk("lu_stall", 32'({stallF, stallD, flushE}), 32'b111);
      idle();
      chk("lu_cnt", 32'(stall_cnt), 32'd1);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      chk("lu_x0", 32'(stallF), 32'd0);

      // Branch beats load-use.
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 5'd0, 5'd5);
      chk("br_ctrl", 32'({flushD, flushE, stallF}), 32'b110);
      idle();
      chk("br_cnt", 32'(flush_cnt), 32'd1);

      // Memory wait of 3 cycles then ready.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b1, (i == 3), 5'd0, 5'd0, 5'd0);
         chk("mw_stall", 32'({stallF, stallD, stallE, stallM, flushW}), 32'b11111);
      end
      idle();
      chk("mw_run", 32'(stallF), 32'd0);
      chk("mw_cnt", 32'(stall_cnt), 32'd4);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
      chk("zero_wait", 32'(stallF), 32'd0);

      // Memory wait overrides branch.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      chk("ovr_flush", 32'({flushD, flushE, stallF}), 32'b001);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
      idle();
      chk("ovr_fcnt", 32'(flush_cnt), 32'd0);

      // Timeout into ERROR; ERROR ignores ready.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
         chk("to_stall", 32'(stallF), 32'd1);
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
         chk("err_ctrl", 32'({stallF, stallM, flushD, flushW}), 32'b1100);
         chk("err_berr", 32'(bus_error), 32'd1);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      chk("err_rst_ctrl", 32'({stallF, flushD, flushE, flushW}), 32'b0111);
      idle();
      chk("err_rst_berr", 32'(bus_error), 32'd0);
      chk("err_rst_cnt", 32'({stall_cnt, flush_cnt}), 32'd0);
      chk("err_rst_run", 32'(stallF), 32'd0);

      // Ready in the last allowed wait cycle.
      for (int i = 0; i < 5; i++)
         drive(1'b0, 1'b0, 1'b0, 1'b1, (i == 4), 5'd0, 5'd0, 5'd0);
      idle();
      chk("late_rdy_run", 32'(stallF), 32'd0);
      chk("late_rdy_berr", 32'(bus_error), 32'd0);

      // Reset in the middle of a wait.
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
      idle();
      chk("wrst_run", 32'(stallF), 32'd0);
      chk("wrst_cnt", 32'(stall_cnt), 32'd0);

      // Saturation of the stall counter.
      for (int i = 0; i < 20; i++)
         drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
      idle();
      chk("sat_cnt", 32'(stall_cnt), 32'(MAXC));
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);

      // Random traffic with varying memory latency and occasional resets.
      for (int blk = 0; blk < 8; blk++) begin
         int thresh;
         thresh = 2 + blk;
         for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) < thresh,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)));
         end
      end
      idle();
      @(posedge clk);
      #1;
      running = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline hazard sequencer for the 5-stage RV32I core; it complements the EX-stage forwarding logic by handling the hazards forwarding cannot resolve.
- Generates per-stage stall and flush controls for three hazard types:
  - load-use hazards;
  - taken branches and jumps resolved in EX;
  - multi-cycle data-memory waits, with a timeout watchdog.
- Maintains saturating stall and flush performance counters.
- Sits beside the pipeline registers; all control outputs are combinational so they act in the same cycle.

Parameters:
- MEM_TIMEOUT, 16: number of consecutive wait cycles on one data-memory access before entering ERROR (legal range 1..255).
- CNT_WIDTH, 32: width of the performance counters.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- rs1D  in  5  source register 1 of the instruction in ID
- rs2D  in  5  source register 2 of the instruction in ID
- rdE  in  5  destination register of the instruction in EX
- loadE  in  1  instruction in EX is a load (result comes from memory)
- PCSrcE  in  1  taken branch or jump resolved in EX
- dmem_reqM  in  1  instruction in MEM performs a data-memory access
- dmem_ready  in  1  data memory completes the access this cycle
- stallF  out  1  hold the PC
- stallD  out  1  hold the IF/ID register
- stallE  out  1  hold the ID/EX register
- stallM  out  1  hold the EX/MEM register
- flushD  out  1  clear the IF/ID register
- flushE  out  1  clear the ID/EX register (inserts a bubble)
- flushW  out  1  clear the MEM/WB register (inserts a bubble)
- bus_error  out  1  sticky flag: a memory-access timeout occurred
- stall_cnt  out  CNT_WIDTH  number of cycles in which stallF=1
- flush_cnt  out  CNT_WIDTH  number of cycles in which PCSrcE caused a flush

Behaviour:
- FSM states: RUN, WAIT, ERROR (registered); wait_ctr is 8 bits, registered.
- Derived signals:
  - memStall = (state==WAIT) | (state==RUN & dmem_reqM & !dmem_ready)
  - lwStall = loadE & (rdE!=0) & ((rs1D==rdE) | (rs2D==rdE))
- Output priority, highest first:
  1. reset=1 or state==ERROR: stallF/D/E/M=1, flushD/E/W=0. In reset itself the pipeline is flushed instead: stalls=0, flushD/E/W=1.
  2. memStall: stallF/D/E/M=1, flushW=1, flushD=flushE=0. PCSrcE and lwStall are ignored because EX is frozen and both are re-evaluated after the stall.
  3. PCSrcE: flushD=1, flushE=1, stallF=stallD=0. The wrong-path ID instruction is discarded, so lwStall is ignored.
  4. lwStall: stallF=stallD=1, flushE=1.
  5. Otherwise all outputs are 0.
- Only stallF/D/E/M and flushD/E/W are combinational. bus_error, stall_cnt and flush_cnt are registered.
- FSM transitions:
  - RUN to WAIT when dmem_reqM & !dmem_ready; wait_ctr<=1.
  - RUN with a zero-wait access (ready in the same cycle): no stall.
  - WAIT to RUN when dmem_ready. The stall still holds in that cycle because MEM completes at the clock edge. wait_ctr<=0.
  - WAIT with !dmem_ready and wait_ctr==MEM_TIMEOUT: go to ERROR, bus_error<=1.
  - WAIT otherwise: wait_ctr increments.
  - Ready and timeout in the same cycle: ready wins (go to RUN).
  - ERROR is terminal until reset.
  - dmem_reqM dropping while in WAIT is ignored; only dmem_ready ends the wait.
- Counters:
  - stall_cnt increments every clock edge where stallF=1 and reset=0, including ERROR cycles.
  - flush_cnt increments on edges where PCSrcE wins (priority 3).
  - Both saturate at all-ones and do not wrap.
- Reset (synchronous, any state, including mid-WAIT): state<=RUN, wait_ctr<=0, bus_error<=0, stall_cnt<=0, flush_cnt<=0. No memory handshake state survives reset.

Test Plan:
- Load-use: loadE=1, rdE=5, rs1D=5 for one cycle → stallF=stallD=flushE=1 that cycle; stall_cnt=1 after the edge. Repeat with rdE=0 → no stall.
- Branch vs load-use: PCSrcE=1 with lwStall conditions true → flushD=flushE=1, stallF=0; flush_cnt increments to 1.
- Memory wait: dmem_reqM=1 with dmem_ready low for 3 cycles, then high → stallF/D/E/M=flushW=1 for 4 cycles; RUN on the 5th; stall_cnt=4. A zero-wait access (ready=1 in the same cycle) → no stall.
- Timeout, MEM_TIMEOUT=4: dmem_ready held low → after 5 stall cycles state=ERROR; bus_error=1; stalls stay 1 indefinitely. Ready arriving in the last wait cycle → RUN and bus_error=0.
- Memory wait overrides branch: PCSrcE=1 during WAIT → flushD=flushE=0, flush_cnt unchanged.
- Reset: assert reset in WAIT and again in ERROR → next cycle state=RUN, bus_error=0, both counters 0; during reset stalls=0 and flushD/E/W=1.
- Counter saturation, CNT_WIDTH=4: hold a stall for 20 cycles → stall_cnt=15.
